// File: rtl/crkt2_core_if.sv
// Signal bundle for crkt2_core: the three function inputs and the registered/combinational results.
interface crkt2_core_if;
  logic       a;
  logic       b;
  logic       c;
  logic       y;
  logic       y_comb;
  logic [2:0] idx;
  logic       y_rise;
  logic       y_fall;

  modport master (
    output a, b, c,
    input  y, y_comb, idx, y_rise, y_fall
  );

  modport slave (
    input  a, b, c,
    output y, y_comb, idx, y_rise, y_fall
  );
endinterface

// File: rtl/crkt2_core.sv
// Registered three-input truth-table lookup with optional input stage,
// combinational tap, sampled minterm index and y edge flags.
module crkt2_core #(
  parameter logic [7:0]  TRUTH_TABLE = 8'hD1,
  parameter int unsigned IN_REG      = 0,
  parameter logic        RESET_Y     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  crkt2_core_if.slave bus
);

  logic [2:0] abc;
  logic [2:0] sample;
  logic       y_next;

  assign abc        = {bus.a, bus.b, bus.c};
  assign bus.y_comb = TRUTH_TABLE[abc];

  generate
    if (IN_REG != 0) begin : g_in_reg
      logic [2:0] in_q;

      always_ff @(posedge clk) begin
        if (reset) in_q <= '0;
        else       in_q <= abc;
      end

      assign sample = in_q;
    end else begin : g_no_in_reg
      assign sample = abc;
    end
  endgenerate

  assign y_next = TRUTH_TABLE[sample];

  // Flags compare against the pre-edge y so they land in the same cycle as the new y.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.y      <= RESET_Y;
      bus.idx    <= '0;
      bus.y_rise <= 1'b0;
      bus.y_fall <= 1'b0;
    end else begin
      bus.y      <= y_next;
      bus.idx    <= sample;
      bus.y_rise <= ~bus.y & y_next;
      bus.y_fall <= bus.y & ~y_next;
    end
  end

endmodule

// File: tb/tb_crkt2_core.sv
// Scoreboard bench for crkt2_core: default table (IN_REG=0 and IN_REG=1) and odd-parity table.
module tb_crkt2_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] abc = 3'b000;

  always #5 clk = ~clk;

  crkt2_core_if bus0 ();
  crkt2_core_if bus1 ();
  crkt2_core_if bus2 ();

  assign {bus0.a, bus0.b, bus0.c} = abc;
  assign {bus1.a, bus1.b, bus1.c} = abc;
  assign {bus2.a, bus2.b, bus2.c} = abc;

  crkt2_core #(.TRUTH_TABLE(8'hD1), .IN_REG(0), .RESET_Y(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  crkt2_core #(.TRUTH_TABLE(8'hD1), .IN_REG(1), .RESET_Y(1'b0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  crkt2_core #(.TRUTH_TABLE(8'h96), .IN_REG(0), .RESET_Y(1'b0))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct packed {
    logic       y;
    logic       y_comb;
    logic [2:0] idx;
    logic       rise;
    logic       fall;
  } exp_t;

  typedef struct {
    int unsigned n;
    exp_t        e[3];
  } sb_t;

  typedef struct {
    logic       rst;
    logic [2:0] abc;
    logic       y0;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic f_def(input logic [2:0] k);
    return (~k[1] & ~k[0]) | (k[2] & k[1]);
  endfunction

  function automatic logic f_par(input logic [2:0] k);
    return k[2] ^ k[1] ^ k[0];
  endfunction

  task automatic add(input logic r, input logic [2:0] v, input logic y0);
    vec_t t;
    t.rst = r;
    t.abc = v;
    t.y0  = y0;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: one registered result per clock, checked #1 after the edge.
  initial begin
    sb_t  s;
    exp_t got[3];
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        got[0] = {bus0.y, bus0.y_comb, bus0.idx, bus0.y_rise, bus0.y_fall};
        got[1] = {bus1.y, bus1.y_comb, bus1.idx, bus1.y_rise, bus1.y_fall};
        got[2] = {bus2.y, bus2.y_comb, bus2.idx, bus2.y_rise, bus2.y_fall};
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("v%0d dut%0d y", s.n, d),      {2'b00, got[d].y},      {2'b00, s.e[d].y});
          chk($sformatf("v%0d dut%0d y_comb", s.n, d), {2'b00, got[d].y_comb}, {2'b00, s.e[d].y_comb});
          chk($sformatf("v%0d dut%0d idx", s.n, d),    got[d].idx,             s.e[d].idx);
          chk($sformatf("v%0d dut%0d y_rise", s.n, d), {2'b00, got[d].rise},   {2'b00, s.e[d].rise});
          chk($sformatf("v%0d dut%0d y_fall", s.n, d), {2'b00, got[d].fall},   {2'b00, s.e[d].fall});
        end
      end
    end
  end

  // Driver: applies vectors on the falling edge and pushes the expected post-edge state.
  initial begin
    logic       my[3];
    logic [2:0] mq[3];
    logic [2:0] smp;
    logic       yn;
    sb_t        s;
    int         wait_cnt;

    // columns: reset, {a,b,c}, hand-derived y for the default table with IN_REG=0
    add(1'b1, 3'b000, 1'b0); add(1'b1, 3'b000, 1'b0);
    add(1'b0, 3'b000, 1'b1); add(1'b0, 3'b000, 1'b1);
    add(1'b0, 3'b001, 1'b0); add(1'b0, 3'b001, 1'b0);
    add(1'b0, 3'b010, 1'b0); add(1'b0, 3'b010, 1'b0);
    add(1'b0, 3'b011, 1'b0); add(1'b0, 3'b011, 1'b0);
    add(1'b0, 3'b100, 1'b1); add(1'b0, 3'b100, 1'b1);
    add(1'b0, 3'b101, 1'b0); add(1'b0, 3'b101, 1'b0);
    add(1'b0, 3'b110, 1'b1); add(1'b0, 3'b110, 1'b1);
    add(1'b0, 3'b111, 1'b1); add(1'b0, 3'b111, 1'b1);
    add(1'b1, 3'b111, 1'b0);
    add(1'b0, 3'b111, 1'b1); add(1'b0, 3'b111, 1'b1);
    add(1'b0, 3'b000, 1'b1); add(1'b0, 3'b000, 1'b1); add(1'b0, 3'b000, 1'b1);
    add(1'b0, 3'b001, 1'b0); add(1'b0, 3'b001, 1'b0); add(1'b0, 3'b001, 1'b0);
    add(1'b0, 3'b000, 1'b1); add(1'b0, 3'b001, 1'b0);
    add(1'b0, 3'b011, 1'b0); add(1'b0, 3'b011, 1'b0);

    for (int d = 0; d < 3; d++) begin
      my[d] = 1'b0;
      mq[d] = 3'b000;
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      abc   = vecs[i].abc;
      s.n   = i;
      for (int d = 0; d < 3; d++) begin
        smp = (d == 1) ? mq[d] : vecs[i].abc;
        if (vecs[i].rst)  yn = 1'b0;
        else if (d == 2)  yn = f_par(smp);
        else              yn = f_def(smp);
        if (d == 0) yn = vecs[i].y0;
        s.e[d].y      = yn;
        s.e[d].y_comb = (d == 2) ? f_par(vecs[i].abc) : f_def(vecs[i].abc);
        s.e[d].idx    = vecs[i].rst ? 3'b000 : smp;
        s.e[d].rise   = vecs[i].rst ? 1'b0 : (~my[d] & yn);
        s.e[d].fall   = vecs[i].rst ? 1'b0 : (my[d] & ~yn);
        my[d] = yn;
        mq[d] = vecs[i].rst ? 3'b000 : vecs[i].abc;
      end
      sb_q.push_back(s);
    end

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
